j1_uart_io: RTL and testbench

- Memory-mapped UART peripheral on the j1 I/O bus; consumes `io_rd`/`io_wr`/`mem_addr`/`dout` from the core and drives the core's `io_din`.
- Provides an 8N1 transmitter, an oversampling-free mid-bit receiver and a small RX FIFO.
- The core polls status and moves bytes one at a time; no interrupts.

---
 rtl/j1_uart_io_if.sv | 11 +
 rtl/j1_uart_io.sv | 148 ++++++++++++++
 tb/tb_j1_uart_io.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/j1_uart_io_if.sv
// j1_uart_io_if: j1 I/O bus between the core (master) and the UART peripheral (slave)
// Signals: io_rd/io_wr one-cycle strobes, mem_addr address, dout write data, io_din read data.
interface j1_uart_io_if;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;
  modport master(output io_rd, io_wr, mem_addr, dout, input io_din);
  modport slave(input io_rd, io_wr, mem_addr, dout, output io_din);
endinterface

// File: rtl/j1_uart_io.sv
// j1_uart_io: memory-mapped 8N1 UART (TX, mid-bit RX, RX FIFO) on the j1 I/O bus
// Ports: clk, resetq (sync active-low), bus (j1_uart_io_if.slave), uart_rx (async in), uart_tx (idle high).
// Registers: DATA at mem_addr[12], STATUS {frame_err, overrun, tx_ready, rx_valid} at mem_addr[13].
// Optional macro J1UART_LOOPBACK_EN adds CTRL at mem_addr[14]; bit0 loops uart_tx back into the receiver.
module j1_uart_io #(
  parameter int CLKDIV   = 104,
  parameter int RX_DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetq,
  j1_uart_io_if.slave   bus,
  input  logic          uart_rx,
  output logic          uart_tx
);
  localparam int CW = $clog2(CLKDIV) + 1;
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] LOAD = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKDIV / 2 - 1);
  localparam logic [CW-1:0] CNT1 = CW'(1);
  localparam logic [AW:0]   PTR1 = (AW + 1)'(1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state, tx_next, rx_state, rx_next;
  logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic [7:0] tx_sh, tx_sh_n, rx_sh, rx_sh_n;
  logic [2:0] sync;
  logic [7:0] fifo [RX_DEPTH];
  logic [AW:0] wp, rp;
  logic overrun, frame_err, push, bad_stop, rx_in;
  logic sel_data, sel_stat, pop, clr, empty, full, do_push, rx_bit_in;
  logic [15:0] ctrl_din;
  logic unused;
  assign sel_data = bus.mem_addr[12];
  assign sel_stat = !bus.mem_addr[12] && bus.mem_addr[13];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop = bus.io_rd && sel_data && !empty;
  assign clr = bus.io_rd && sel_stat;
  // A push into a full FIFO still lands when the head is popped at the same edge.
  assign do_push = push && (!full || pop);
  // sync[1] is the synchronized line; sync[2] is its previous value for edge detection.
  assign rx_bit_in = sync[1];
  assign unused = ^{bus.mem_addr[15:14], bus.mem_addr[11:0], bus.dout[15:8]};
`ifdef J1UART_LOOPBACK_EN
  logic loop, sel_ctrl;
  assign sel_ctrl = !bus.mem_addr[12] && !bus.mem_addr[13] && bus.mem_addr[14];
  assign ctrl_din = sel_ctrl ? {15'h0000, loop} : 16'h0000;
  assign rx_in = loop ? uart_tx : uart_rx;
  always_ff @(posedge clk)
    if (!resetq) loop <= 1'b0;
    else if (bus.io_wr && sel_ctrl) loop <= bus.dout[0];
`else
  assign ctrl_din = 16'h0000;
  assign rx_in = uart_rx;
`endif
  assign bus.io_din = sel_data ? (empty ? 16'h0000 : {8'h00, fifo[rp[AW-1:0]]}) :
                      sel_stat ? {12'h000, frame_err, overrun, tx_state == IDLE, !empty} : ctrl_din;
  assign uart_tx = (tx_state == START) ? 1'b0 : (tx_state == DATA) ? tx_sh[0] : 1'b1;
  always_comb begin
    tx_next = tx_state;
    tx_cnt_n = tx_cnt - CNT1;
    tx_bit_n = tx_bit;
    tx_sh_n = tx_sh;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = LOAD;
        if (bus.io_wr && sel_data) begin
          tx_next = START;
          tx_sh_n = bus.dout[7:0];
        end
      end
      START: if (tx_cnt == '0) begin
        tx_next = DATA;
        tx_cnt_n = LOAD;
        tx_bit_n = 3'd0;
      end
      DATA: if (tx_cnt == '0) begin
        tx_next = (tx_bit == 3'd7) ? STOP : DATA;
        tx_cnt_n = LOAD;
        tx_bit_n = tx_bit + 3'd1;
        tx_sh_n = tx_sh >> 1;
      end
      STOP: if (tx_cnt == '0) tx_next = IDLE;
    endcase
  end
  always_comb begin
    rx_next = rx_state;
    rx_cnt_n = rx_cnt - CNT1;
    rx_bit_n = rx_bit;
    rx_sh_n = rx_sh;
    push = 1'b0;
    bad_stop = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = HALF;
        if (sync[2] && !sync[1]) rx_next = START;
      end
      START: if (rx_cnt == '0) begin
        rx_next = rx_bit_in ? IDLE : DATA;
        rx_cnt_n = LOAD;
        rx_bit_n = 3'd0;
      end
      DATA: if (rx_cnt == '0) begin
        rx_next = (rx_bit == 3'd7) ? STOP : DATA;
        rx_cnt_n = LOAD;
        rx_bit_n = rx_bit + 3'd1;
        rx_sh_n = {rx_bit_in, rx_sh[7:1]};
      end
      STOP: if (rx_cnt == '0) begin
        rx_next = IDLE;
        push = rx_bit_in;
        bad_stop = !rx_bit_in;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (!resetq) begin
      tx_state <= IDLE;
      rx_state <= IDLE;
      tx_cnt <= '0;
      rx_cnt <= '0;
      tx_bit <= 3'd0;
      rx_bit <= 3'd0;
      tx_sh <= 8'h00;
      rx_sh <= 8'h00;
      sync <= 3'b111;
      wp <= '0;
      rp <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      tx_cnt <= tx_cnt_n;
      rx_cnt <= rx_cnt_n;
      tx_bit <= tx_bit_n;
      rx_bit <= rx_bit_n;
      tx_sh <= tx_sh_n;
      rx_sh <= rx_sh_n;
      sync <= {sync[1:0], rx_in};
      wp <= do_push ? wp + PTR1 : wp;
      rp <= pop ? rp + PTR1 : rp;
      overrun <= (overrun && !clr) || (push && full && !pop);
      frame_err <= (frame_err && !clr) || bad_stop;
    end
  always_ff @(posedge clk)
    if (resetq && do_push) fifo[wp[AW-1:0]] <= rx_sh;
endmodule

// File: tb/tb_j1_uart_io.sv
// tb_j1_uart_io: self-checking bench for j1_uart_io with CLKDIV=8, RX_DEPTH=4
module tb_j1_uart_io;
  localparam int C = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic resetq;
  logic uart_rx, uart_tx;
  j1_uart_io_if bus();
  j1_uart_io #(.CLKDIV(C), .RX_DEPTH(D)) dut (
    .clk(clk), .resetq(resetq), .bus(bus), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, tx_start = 0;
  bit started = 0, chk_en = 0, m_ovr = 0, m_fe = 0, m_loop = 0;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] q[$];
  int pend_n = 0, seen_n = 0;
  logic [7:0] pend_byte;
  bit pend_stop;
  bit lit_on = 0, lit_sig = 0;
  logic [15:0] lit_exp;
  string lit_name;
  logic [9:0] pat = 10'b1101001010;
  function automatic bit busy_at(int c);
    return started && (c - tx_start) < 10 * C;
  endfunction
  function automatic logic exp_tx();
    logic [9:0] fr;
    fr = {1'b1, tx_byte, 1'b0};
    return busy_at(cyc) ? fr[(cyc - tx_start) / C] : 1'b1;
  endfunction
  function automatic logic [15:0] exp_din(logic [15:0] a);
    if (a[12]) return (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
    if (a[13]) return {12'h000, m_fe, m_ovr, !busy_at(cyc), q.size() != 0};
`ifdef J1UART_LOOPBACK_EN
    if (a[14]) return {15'h0000, m_loop};
`endif
    return 16'h0000;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (!resetq) begin
      started = 0;
      q.delete();
      m_ovr = 0;
      m_fe = 0;
      m_loop = 0;
      seen_n = pend_n;
    end else begin
      if (bus.io_wr && bus.mem_addr[12] && !busy_at(cyc - 1)) begin
        started = 1;
        tx_start = cyc;
        tx_byte = bus.dout[7:0];
      end
      if (bus.io_wr && !bus.mem_addr[12] && !bus.mem_addr[13] && bus.mem_addr[14]) m_loop = bus.dout[0];
      if (bus.io_rd && bus.mem_addr[12] && q.size() != 0) void'(q.pop_front());
      if (bus.io_rd && !bus.mem_addr[12] && bus.mem_addr[13]) begin
        m_ovr = 0;
        m_fe = 0;
      end
      if (pend_n != seen_n) begin
        seen_n = pend_n;
        if (!pend_stop) m_fe = 1;
        else if (q.size() == D) m_ovr = 1;
        else q.push_back(pend_byte);
      end
    end
  end
  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      cmp("tx_model", {15'h0000, uart_tx}, {15'h0000, exp_tx()});
      if (bus.io_rd) cmp("din_model", bus.io_din, exp_din(bus.mem_addr));
      if (lit_on) cmp(lit_name, lit_sig ? {15'h0000, uart_tx} : bus.io_din, lit_exp);
    end
  task automatic rdx(input logic [15:0] a, input logic [15:0] exp, input string nm);
    @(posedge clk); #1;
    bus.mem_addr = a;
    bus.io_rd = 1'b1;
    lit_on = 1; lit_sig = 0; lit_exp = exp; lit_name = nm;
    @(posedge clk); #1;
    bus.io_rd = 1'b0;
    bus.mem_addr = 16'h0000;
    lit_on = 0;
  endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    @(posedge clk); #1;
    bus.mem_addr = a;
    bus.dout = v;
    bus.io_wr = 1'b1;
    @(posedge clk); #1;
    bus.io_wr = 1'b0;
    bus.mem_addr = 16'h0000;
  endtask
  task automatic expect_tx(input logic v, input string nm);
    lit_on = 1; lit_sig = 1; lit_exp = {15'h0000, v}; lit_name = nm;
    @(negedge clk); #1;
    lit_on = 0;
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (C) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (C) @(posedge clk);
    #1;
    pend_byte = b;
    pend_stop = stop;
    pend_n++;
  endtask
  initial begin
    resetq = 1'b0;
    uart_rx = 1'b1;
    bus.io_rd = 1'b0;
    bus.io_wr = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.dout = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    resetq = 1'b1;
    chk_en = 1;
    expect_tx(1'b1, "reset_tx");
    rdx(16'h2000, 16'h0002, "reset_status");
    rdx(16'h0000, 16'h0000, "unselected");
    rdx(16'h4000, 16'h0000, "ctrl_reset");
    rdx(16'h1000, 16'h0000, "reset_data_empty");
    wr(16'h1000, 16'h00A5);
    repeat (C / 2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      expect_tx(pat[i], $sformatf("tx_bit%0d", i));
      if (i == 5) begin
        rdx(16'h2000, 16'h0000, "tx_busy_status");
        repeat (C - 2) @(posedge clk);
      end else if (i == 7) begin
        wr(16'h1000, 16'h00FF);
        repeat (C - 2) @(posedge clk);
      end else repeat (C) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;
    rdx(16'h2000, 16'h0002, "tx_done_status");
    send(8'h3C, 1'b1);
    rdx(16'h2000, 16'h0003, "rx_status");
    rdx(16'h1000, 16'h003C, "rx_data");
    rdx(16'h1000, 16'h0000, "rx_data_empty");
    rdx(16'h2000, 16'h0002, "rx_valid_clear");
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    rdx(16'h2000, 16'h0007, "ovf_status");
    rdx(16'h3000, 16'h0001, "ovf_rd1_data_wins");
    rdx(16'h1000, 16'h0002, "ovf_rd2");
    rdx(16'h1000, 16'h0003, "ovf_rd3");
    rdx(16'h1000, 16'h0004, "ovf_rd4");
    rdx(16'h1000, 16'h0000, "ovf_rd_empty");
    rdx(16'h2000, 16'h0002, "ovf_cleared");
    uart_rx = 1'b0;
    @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    rdx(16'h2000, 16'h0002, "glitch_status");
    rdx(16'h1000, 16'h0000, "glitch_nopush");
    send(8'h55, 1'b0);
    rdx(16'h2000, 16'h000A, "fe_status");
    rdx(16'h2000, 16'h0002, "fe_cleared");
    rdx(16'h1000, 16'h0000, "fe_nopush");
    send(8'h77, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * C) @(posedge clk);
    #1;
    resetq = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetq = 1'b1;
    rdx(16'h2000, 16'h0002, "midrx_rst_status");
    rdx(16'h1000, 16'h0000, "midrx_rst_empty");
    send(8'h99, 1'b1);
    rdx(16'h1000, 16'h0099, "post_rst_rx");
`ifdef J1UART_LOOPBACK_EN
    wr(16'h4000, 16'h0001);
    rdx(16'h4000, 16'h0001, "loop_ctrl");
    wr(16'h1000, 16'h005A);
    repeat (10 * C + 3) @(posedge clk);
    #1;
    pend_byte = 8'h5A;
    pend_stop = 1'b1;
    pend_n++;
    rdx(16'h1000, 16'h005A, "loop_data");
    wr(16'h4000, 16'h0000);
    rdx(16'h4000, 16'h0000, "loop_off");
`endif
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
